// File: rtl/id_branch_ctrl.sv
// ID-stage branch resolver: IF/ID register, R2000 delay slot, redirect to fetch, taken counter.
// Latency: taken branch in ID at T -> br at T+1 -> target valid in ID at T+3; stall freezes all but except.
module id_branch_ctrl #(
    parameter int          CNT_W      = 16,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0080
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      inst_in,
    input  logic             stall,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             except_req,
    output logic [31:0]      pc_id,
    output logic [31:0]      inst_id,
    output logic             valid_id,
    output logic             br,
    output logic [31:0]      sign,
    output logic             except,
    output logic [31:0]      fixed,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {RUN, SLOT} state_t;

    state_t      state;
    logic        exc_pend;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        taken;
    logic [31:0] target;

    assign op        = inst_id[31:26];
    assign funct     = inst_id[5:0];
    assign pc_plus4  = pc_id + 32'd4;
    assign br_target = pc_plus4 + {{14{inst_id[15]}}, inst_id[15:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], inst_id[25:0], 2'b00};
    assign fixed     = EXC_VECTOR;

    // The instruction sitting in the delay slot is never resolved (decode off in SLOT).
    always_comb begin
        taken  = 1'b0;
        target = br_target;
        if (valid_id && state == RUN) begin
            case (op)
                6'h04: taken = (rs_data == rt_data);
                6'h05: taken = (rs_data != rt_data);
                6'h06: taken = ($signed(rs_data) <= 32'sd0);
                6'h07: taken = ($signed(rs_data) > 32'sd0);
                6'h02, 6'h03: begin
                    taken  = 1'b1;
                    target = j_target;
                end
                6'h00: begin
                    if (funct == 6'h08) begin
                        taken  = 1'b1;
                        target = rs_data;
                    end
                end
                default: taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_id     <= '0;
            inst_id   <= '0;
            valid_id  <= 1'b0;
            br        <= 1'b0;
            sign      <= '0;
            except    <= 1'b0;
            taken_cnt <= '0;
            state     <= RUN;
            exc_pend  <= 1'b0;
        end else if (except_req) begin
            // exc_pend kills the next capture too: it is the in-flight wrong-path fetch.
            except   <= 1'b1;
            br       <= 1'b0;
            state    <= RUN;
            valid_id <= 1'b0;
            exc_pend <= 1'b1;
            if (!stall) begin
                pc_id   <= pc_in;
                inst_id <= inst_in;
            end
        end else begin
            except <= 1'b0;
            if (!stall) begin
                pc_id    <= pc_in;
                inst_id  <= inst_in;
                valid_id <= !(state == SLOT || exc_pend);
                exc_pend <= 1'b0;
                if (state == SLOT) begin
                    br    <= 1'b0;
                    state <= RUN;
                end else if (taken) begin
                    br    <= 1'b1;
                    sign  <= target;
                    state <= SLOT;
                    if (taken_cnt != '1) begin
                        taken_cnt <= taken_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_id_branch_ctrl.sv
// Bench for id_branch_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_id_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic [31:0] inst_in = '0;
    logic        stall = 1'b0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        except_req = 1'b0;
    logic [31:0] pc_id;
    logic [31:0] inst_id;
    logic        valid_id;
    logic        br;
    logic [31:0] sign;
    logic        except;
    logic [31:0] fixed;
    logic [15:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ALU  = 32'h2108_0001;
    localparam logic [31:0] BEQ3 = 32'h1000_0003;
    localparam logic [31:0] BNE5 = 32'h1400_0005;
    localparam logic [31:0] JINS = 32'h0800_0040;
    localparam logic [31:0] BGTZ = 32'h1C00_FFFF;
    localparam logic [31:0] JR31 = 32'h03E0_0008;

    id_branch_ctrl dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .inst_in(inst_in), .stall(stall),
        .rs_data(rs_data), .rt_data(rt_data), .except_req(except_req),
        .pc_id(pc_id), .inst_id(inst_id), .valid_id(valid_id), .br(br), .sign(sign),
        .except(except), .fixed(fixed), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: architectural view of the ID slot and pending squashes.
    logic [31:0] m_pc, m_inst, m_sign;
    logic        m_valid, m_br, m_except;
    logic [15:0] m_cnt;
    int          kill_next;

    task automatic model_reset();
        m_pc = '0; m_inst = '0; m_sign = '0; m_valid = 1'b0; m_br = 1'b0;
        m_except = 1'b0; m_cnt = '0; kill_next = 0;
    endtask

    function automatic void ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                       input logic [31:0] rs, input logic [31:0] rt,
                                       output bit tk, output logic [31:0] tgt);
        int imm;
        imm = int'($signed(inst[15:0]));
        tk  = 1'b0;
        tgt = pc + 32'd4 + 32'(imm * 4);
        case (inst[31:26])
            6'h04: tk = (rs == rt);
            6'h05: tk = (rs != rt);
            6'h06: tk = ($signed(rs) <= 0);
            6'h07: tk = ($signed(rs) > 0);
            6'h02, 6'h03: begin
                tk  = 1'b1;
                tgt = ((pc + 32'd4) & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) << 2);
            end
            6'h00: if (inst[5:0] == 6'h08) begin tk = 1'b1; tgt = rs; end
            default: tk = 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        bit          tk;
        logic [31:0] tgt;
        ref_decode(m_inst, m_pc, rs_data, rt_data, tk, tgt);
        tk = tk && m_valid && !m_br;
        if (except_req) begin
            m_except = 1'b1; m_br = 1'b0; m_valid = 1'b0; kill_next = 1;
            if (!stall) begin m_pc = pc_in; m_inst = inst_in; end
        end else begin
            m_except = 1'b0;
            if (!stall) begin
                m_valid = (kill_next == 0);
                if (kill_next > 0) kill_next--;
                if (m_br) m_br = 1'b0;
                else if (tk) begin
                    m_br = 1'b1; m_sign = tgt; kill_next = 1;
                    if (m_cnt != 16'hFFFF) m_cnt++;
                end
                m_pc = pc_in; m_inst = inst_in;
            end
        end
    endtask

    task automatic cyc(input logic [31:0] pc, input logic [31:0] ins, input logic stl,
                       input logic [31:0] rs, input logic [31:0] rt, input logic exc);
        pc_in = pc; inst_in = ins; stall = stl; rs_data = rs; rt_data = rt; except_req = exc;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (pc_id !== 32'h0 || inst_id !== 32'h0) begin errors++; $display("FAIL reset_pc_inst: got %h/%h want 0/0", pc_id, inst_id); end
        checks++; if (valid_id !== 1'b0 || br !== 1'b0 || except !== 1'b0) begin errors++; $display("FAIL reset_flags: got v=%b br=%b ex=%b want 0", valid_id, br, except); end
        checks++; if (sign !== 32'h0 || taken_cnt !== 16'h0) begin errors++; $display("FAIL reset_sign_cnt: got %h/%0d want 0/0", sign, taken_cnt); end
        checks++; if (fixed !== 32'h8000_0080) begin errors++; $display("FAIL reset_fixed: got %h want 80000080", fixed); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 8; i++) begin
            cyc(32'(i * 4), ALU, 1'b0, 32'h1, 32'h2, 1'b0);
            checks++;
            if (pc_id !== 32'(i * 4) || valid_id !== 1'b1 || br !== 1'b0 || taken_cnt !== 16'd0) begin
                errors++; $display("FAIL seq_%0d: got pc=%h v=%b br=%b cnt=%0d want pc=%h v=1 br=0 cnt=0", i, pc_id, valid_id, br, taken_cnt, i * 4);
            end
        end
    endtask

    task automatic test_beq();
        cyc(32'h10, BEQ3, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc(32'h14, ALU, 1'b0, 32'd5, 32'd5, 1'b0);
        checks++; if (br !== 1'b1 || sign !== 32'h20) begin errors++; $display("FAIL beq_redirect: got br=%b sign=%h want 1/00000020", br, sign); end
        checks++; if (pc_id !== 32'h14 || valid_id !== 1'b1 || taken_cnt !== 16'd1) begin errors++; $display("FAIL beq_slot: got pc=%h v=%b cnt=%0d want 14/1/1", pc_id, valid_id, taken_cnt); end
        cyc(32'h18, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
        checks++; if (br !== 1'b0 || pc_id !== 32'h18 || valid_id !== 1'b0) begin errors++; $display("FAIL beq_squash: got br=%b pc=%h v=%b want 0/18/0", br, pc_id, valid_id); end
        cyc(32'h20, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
        checks++; if (pc_id !== 32'h20 || valid_id !== 1'b1) begin errors++; $display("FAIL beq_target: got pc=%h v=%b want 20/1", pc_id, valid_id); end
    endtask

    task automatic test_bne_j();
        cyc(32'h100, BNE5, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(32'h104, ALU, 1'b0, 32'd7, 32'd7, 1'b0);
        checks++; if (br !== 1'b0 || valid_id !== 1'b1) begin errors++; $display("FAIL bne_not_taken: got br=%b v=%b want 0/1", br, valid_id); end
        cyc(32'h108, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
        checks++; if (valid_id !== 1'b1 || taken_cnt !== 16'd1) begin errors++; $display("FAIL bne_no_squash: got v=%b cnt=%0d want 1/1", valid_id, taken_cnt); end
        cyc(32'h1000_0000, JINS, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(32'h1000_0004, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
        checks++; if (br !== 1'b1 || sign !== 32'h1000_0100) begin errors++; $display("FAIL j_target: got br=%b sign=%h want 1/10000100", br, sign); end
        cyc(32'h1000_0008, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
        checks++; if (valid_id !== 1'b0 || taken_cnt !== 16'd2) begin errors++; $display("FAIL j_squash: got v=%b cnt=%0d want 0/2", valid_id, taken_cnt); end
        cyc(32'h1000_0100, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_bgtz_jr();
        cyc(32'h40, BGTZ, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(32'h44, ALU, 1'b0, 32'd1, 32'd0, 1'b0);
        checks++; if (br !== 1'b1 || sign !== 32'h40) begin errors++; $display("FAIL bgtz_back: got br=%b sign=%h want 1/00000040", br, sign); end
        cyc(32'h48, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(32'h40, JR31, 1'b0, 32'd0, 32'd0, 1'b0);
        checks++; if (valid_id !== 1'b1 || br !== 1'b0) begin errors++; $display("FAIL bgtz_arrive: got v=%b br=%b want 1/0", valid_id, br); end
        cyc(32'h44, ALU, 1'b0, 32'hDEAD_BEE0, 32'd0, 1'b0);
        checks++; if (br !== 1'b1 || sign !== 32'hDEAD_BEE0 || taken_cnt !== 16'd4) begin errors++; $display("FAIL jr_target: got br=%b sign=%h cnt=%0d want 1/deadbee0/4", br, sign, taken_cnt); end
        cyc(32'h48, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(32'hDEAD_BEE0, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_exception();
        cyc(32'h200, BEQ3, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(32'h204, ALU, 1'b0, 32'd3, 32'd3, 1'b1);
        checks++; if (except !== 1'b1 || br !== 1'b0 || valid_id !== 1'b0) begin errors++; $display("FAIL exc_hit: got ex=%b br=%b v=%b want 1/0/0", except, br, valid_id); end
        checks++; if (taken_cnt !== 16'd4 || fixed !== 32'h8000_0080) begin errors++; $display("FAIL exc_cnt_fixed: got cnt=%0d fixed=%h want 4/80000080", taken_cnt, fixed); end
        cyc(32'h208, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
        checks++; if (except !== 1'b0 || valid_id !== 1'b0 || br !== 1'b0) begin errors++; $display("FAIL exc_second_squash: got ex=%b v=%b br=%b want 0/0/0", except, valid_id, br); end
        cyc(32'h20C, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
        checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL exc_resume: got v=%b want 1", valid_id); end
    endtask

    task automatic test_stall_slot();
        cyc(32'h300, BEQ3, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(32'h304, ALU, 1'b0, 32'd9, 32'd9, 1'b0);
        checks++; if (br !== 1'b1 || sign !== 32'h310) begin errors++; $display("FAIL stall_redirect: got br=%b sign=%h want 1/00000310", br, sign); end
        for (int i = 0; i < 3; i++) begin
            cyc(32'h308, BNE5, 1'b1, 32'd1, 32'd2, 1'b0);
            checks++;
            if (br !== 1'b1 || pc_id !== 32'h304 || inst_id !== ALU || taken_cnt !== 16'd5) begin
                errors++; $display("FAIL stall_hold_%0d: got br=%b pc=%h inst=%h cnt=%0d want 1/304/%h/5", i, br, pc_id, inst_id, taken_cnt, ALU);
            end
        end
        cyc(32'h308, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
        checks++; if (br !== 1'b0 || valid_id !== 1'b0 || pc_id !== 32'h308) begin errors++; $display("FAIL stall_squash: got br=%b v=%b pc=%h want 0/0/308", br, valid_id, pc_id); end
        cyc(32'h310, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
        checks++; if (valid_id !== 1'b1 || pc_id !== 32'h310) begin errors++; $display("FAIL stall_target: got v=%b pc=%h want 1/310", valid_id, pc_id); end
        cyc(32'h400, BEQ3, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(32'h404, ALU, 1'b0, 32'd1, 32'd1, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (br !== 1'b0 || pc_id !== 32'h0 || inst_id !== 32'h0 || valid_id !== 1'b0 || sign !== 32'h0 || taken_cnt !== 16'd0 || except !== 1'b0) begin
            errors++; $display("FAIL midslot_reset: got br=%b pc=%h inst=%h v=%b sign=%h cnt=%0d ex=%b want all 0", br, pc_id, inst_id, valid_id, sign, taken_cnt, except);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc(32'h500, ALU, 1'b0, 32'd0, 32'd0, 1'b0);
        checks++; if (valid_id !== 1'b1 || br !== 1'b0) begin errors++; $display("FAIL post_reset_no_squash: got v=%b br=%b want 1/0", valid_id, br); end
    endtask

    task automatic test_random();
        logic [31:0] r, ins, rs, rt, pc;
        logic        stl, exc;
        for (int n = 0; n < 400; n++) begin
            r  = $urandom();
            pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            case ($urandom_range(0, 8))
                0: ins = {6'h04, r[25:0]};
                1: ins = {6'h05, r[25:0]};
                2: ins = {6'h06, r[25:0]};
                3: ins = {6'h07, r[25:0]};
                4: ins = {6'h02, r[25:0]};
                5: ins = {6'h03, r[25:0]};
                6: ins = {6'h00, r[25:6], 6'h08};
                7: ins = {6'h00, r[25:6], 6'h20};
                default: ins = {6'h23, r[25:0]};
            endcase
            case ($urandom_range(0, 4))
                0: rs = 32'h0;
                1: rs = 32'h1;
                2: rs = 32'hFFFF_FFFF;
                3: rs = 32'h8000_0000;
                default: rs = $urandom();
            endcase
            rt  = ($urandom_range(0, 1) == 1) ? rs : $urandom();
            exc = ($urandom_range(0, 19) == 0);
            stl = !exc && ($urandom_range(0, 6) == 0);
            cyc(pc, ins, stl, rs, rt, exc);
            checks++; if (pc_id !== m_pc) begin errors++; $display("FAIL rnd_pc_id @%0d: got %h want %h", n, pc_id, m_pc); end
            checks++; if (inst_id !== m_inst) begin errors++; $display("FAIL rnd_inst_id @%0d: got %h want %h", n, inst_id, m_inst); end
            checks++; if (valid_id !== m_valid) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", n, valid_id, m_valid); end
            checks++; if (br !== m_br) begin errors++; $display("FAIL rnd_br @%0d: got %b want %b", n, br, m_br); end
            checks++; if (sign !== m_sign) begin errors++; $display("FAIL rnd_sign @%0d: got %h want %h", n, sign, m_sign); end
            checks++; if (except !== m_except) begin errors++; $display("FAIL rnd_except @%0d: got %b want %b", n, except, m_except); end
            checks++; if (taken_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", n, taken_cnt, m_cnt); end
            checks++; if (fixed !== 32'h8000_0080) begin errors++; $display("FAIL rnd_fixed @%0d: got %h want 80000080", n, fixed); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_beq();
        test_bne_j();
        test_bgtz_jr();
        test_exception();
        test_stall_slot();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
